// File: rtl/pipe_memwb_skid.sv
// MEM/WB pipeline stage with valid/ready handshake, two-entry skid buffer and synchronous flush.
// Optional forwarding port set enabled by defining PIPE_MEMWB_FWD_EN.
module pipe_memwb_skid #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int WB_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   WB_i,
  input  logic [DATA_W-1:0] FUresult_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] memReadData_i,
`ifdef PIPE_MEMWB_FWD_EN
  input  logic [ADDR_W-1:0] fwdQueryAddr_i,
  output logic              fwdHit_o,
  output logic [DATA_W-1:0] fwdData_o,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   WB_o,
  output logic [DATA_W-1:0] FUresult_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] memReadData_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_t;

  state_t state_r, state_next_s;

  logic              main_valid_r, skid_valid_r, in_ready_r;
  logic [WB_W-1:0]   main_wb_r,   skid_wb_r;
  logic [DATA_W-1:0] main_fu_r,   skid_fu_r;
  logic [ADDR_W-1:0] main_rd_r,   skid_rd_r;
  logic [DATA_W-1:0] main_mem_r,  skid_mem_r;

  logic accept_s, consume_s;
  logic load_main_in_s, load_skid_s, move_skid_s;

  assign accept_s  = in_valid_i & in_ready_r;
  assign consume_s = main_valid_r & out_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; flush overrides any simultaneous handshake
  always_comb begin
    state_next_s = state_r;
    if (flush_i) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_next_s = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (accept_s && !consume_s) begin
            state_next_s = ST_TWO;
          end else if (!accept_s && consume_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_TWO:   state_next_s = consume_s ? ST_ONE : ST_TWO;
        default:  state_next_s = ST_EMPTY;
      endcase
    end
  end

  // Datapath steering decoded from current state and handshakes
  always_comb begin
    load_main_in_s = 1'b0;
    load_skid_s    = 1'b0;
    move_skid_s    = 1'b0;
    if (!flush_i) begin
      case (state_r)
        ST_EMPTY: load_main_in_s = accept_s;
        ST_ONE: begin
          load_main_in_s = accept_s & consume_s;
          load_skid_s    = accept_s & ~consume_s;
        end
        ST_TWO:   move_skid_s = consume_s & skid_valid_r;
        default: begin
          load_main_in_s = 1'b0;
          load_skid_s    = 1'b0;
          move_skid_s    = 1'b0;
        end
      endcase
    end else begin
      load_main_in_s = 1'b0;
      load_skid_s    = 1'b0;
      move_skid_s    = 1'b0;
    end
  end

  // Entry valid bits and ready, registered from next state to keep out_ready_i off the ready path
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= (state_next_s != ST_EMPTY);
      skid_valid_r <= (state_next_s == ST_TWO);
      in_ready_r   <= (state_next_s != ST_TWO);
    end
  end

  // Main entry payload
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      main_wb_r  <= {WB_W{1'b0}};
      main_fu_r  <= {DATA_W{1'b0}};
      main_rd_r  <= {ADDR_W{1'b0}};
      main_mem_r <= {DATA_W{1'b0}};
    end else if (load_main_in_s) begin
      main_wb_r  <= WB_i;
      main_fu_r  <= FUresult_i;
      main_rd_r  <= RDaddr_i;
      main_mem_r <= memReadData_i;
    end else if (move_skid_s) begin
      main_wb_r  <= skid_wb_r;
      main_fu_r  <= skid_fu_r;
      main_rd_r  <= skid_rd_r;
      main_mem_r <= skid_mem_r;
    end
  end

  // Skid entry payload
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      skid_wb_r  <= {WB_W{1'b0}};
      skid_fu_r  <= {DATA_W{1'b0}};
      skid_rd_r  <= {ADDR_W{1'b0}};
      skid_mem_r <= {DATA_W{1'b0}};
    end else if (load_skid_s) begin
      skid_wb_r  <= WB_i;
      skid_fu_r  <= FUresult_i;
      skid_rd_r  <= RDaddr_i;
      skid_mem_r <= memReadData_i;
    end
  end

  assign in_ready_o    = in_ready_r;
  assign out_valid_o   = main_valid_r;
  // regWrite must never be seen asserted without a valid payload
  assign WB_o          = {main_wb_r[WB_W-1:1], main_wb_r[0] & main_valid_r};
  assign FUresult_o    = main_fu_r;
  assign RDaddr_o      = main_rd_r;
  assign memReadData_o = main_mem_r;

`ifdef PIPE_MEMWB_FWD_EN
  assign fwdHit_o  = main_valid_r & WB_o[0] & (main_rd_r == fwdQueryAddr_i) &
                     (main_rd_r != {ADDR_W{1'b0}});
  assign fwdData_o = main_wb_r[1] ? main_mem_r : main_fu_r;
`endif

endmodule

// File: tb/tb_pipe_memwb_skid.sv
// Directed self-checking bench for pipe_memwb_skid.
module tb_pipe_memwb_skid;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int WB_W   = 2;

  logic              clk_i = 1'b0;
  logic              rst_n;
  logic              flush_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [WB_W-1:0]   WB_i;
  logic [DATA_W-1:0] FUresult_i;
  logic [ADDR_W-1:0] RDaddr_i;
  logic [DATA_W-1:0] memReadData_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [WB_W-1:0]   WB_o;
  logic [DATA_W-1:0] FUresult_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] memReadData_o;
`ifdef PIPE_MEMWB_FWD_EN
  logic [ADDR_W-1:0] fwdQueryAddr_i;
  logic              fwdHit_o;
  logic [DATA_W-1:0] fwdData_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  pipe_memwb_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_W(WB_W)) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .WB_i          (WB_i),
    .FUresult_i    (FUresult_i),
    .RDaddr_i      (RDaddr_i),
    .memReadData_i (memReadData_i),
`ifdef PIPE_MEMWB_FWD_EN
    .fwdQueryAddr_i(fwdQueryAddr_i),
    .fwdHit_o      (fwdHit_o),
    .fwdData_o     (fwdData_o),
`endif
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .WB_o          (WB_o),
    .FUresult_o    (FUresult_o),
    .RDaddr_o      (RDaddr_o),
    .memReadData_o (memReadData_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one clock, then settle past the edge before sampling or driving.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] wb, input logic [15:0] fu,
                       input logic [2:0] rd, input logic [15:0] mem);
    in_valid_i    = v;
    WB_i          = wb;
    FUresult_i    = fu;
    RDaddr_i      = rd;
    memReadData_i = mem;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 3'd0, 16'h0000);
`ifdef PIPE_MEMWB_FWD_EN
    fwdQueryAddr_i = 3'd0;
`endif

    // Reset state
    step();
    step();
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_ready", 32'(in_ready_o), 32'd1);
    check("rst_fu", 32'(FUresult_o), 32'd0);
    check("rst_wb", 32'(WB_o), 32'd0);
    check("rst_rd", 32'(RDaddr_o), 32'd0);
    check("rst_mem", 32'(memReadData_o), 32'd0);
    @(negedge clk_i);
    rst_n = 1'b1;
    #1;

    // Streaming 1..8 with out_ready held high
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'b01, 16'(i), 3'(i), 16'h0000);
      step();
      check("stream_valid", 32'(out_valid_o), 32'd1);
      check("stream_fu", 32'(FUresult_o), 32'(i));
      check("stream_ready", 32'(in_ready_o), 32'd1);
    end
    drive(1'b0, 2'b00, 16'h0000, 3'd0, 16'h0000);
    step();
    check("stream_drain", 32'(out_valid_o), 32'd0);
    check("stream_wb_gate", 32'(WB_o), 32'd0);

    // Stall: A1 and A2 absorbed, A3 held off
    out_ready_i = 1'b0;
    drive(1'b1, 2'b01, 16'h00A1, 3'd1, 16'h0000);
    step();
    check("stall_a1_fu", 32'(FUresult_o), 32'h00A1);
    check("stall_a1_ready", 32'(in_ready_o), 32'd1);
    drive(1'b1, 2'b01, 16'h00A2, 3'd2, 16'h0000);
    step();
    check("stall_two_ready", 32'(in_ready_o), 32'd0);
    check("stall_two_fu", 32'(FUresult_o), 32'h00A1);
    drive(1'b1, 2'b01, 16'h00A3, 3'd3, 16'h0000);
    step();
    check("stall_hold_ready", 32'(in_ready_o), 32'd0);
    check("stall_hold_fu", 32'(FUresult_o), 32'h00A1);
    check("stall_hold_rd", 32'(RDaddr_o), 32'd1);
    out_ready_i = 1'b1;
    step();
    check("release_a2", 32'(FUresult_o), 32'h00A2);
    check("release_ready", 32'(in_ready_o), 32'd1);
    step();
    check("release_a3", 32'(FUresult_o), 32'h00A3);
    check("release_a3_valid", 32'(out_valid_o), 32'd1);
    drive(1'b0, 2'b00, 16'h0000, 3'd0, 16'h0000);
    step();
    check("release_empty", 32'(out_valid_o), 32'd0);

    // Flush while full with a simultaneous consume
    out_ready_i = 1'b0;
    drive(1'b1, 2'b01, 16'h00B1, 3'd4, 16'h0000);
    step();
    drive(1'b1, 2'b01, 16'h00B2, 3'd5, 16'h0000);
    step();
    check("pre_flush_ready", 32'(in_ready_o), 32'd0);
    check("pre_flush_wb0", 32'(WB_o[0]), 32'd1);
    drive(1'b0, 2'b00, 16'h0000, 3'd0, 16'h0000);
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("flush_valid", 32'(out_valid_o), 32'd0);
    check("flush_wb0", 32'(WB_o[0]), 32'd0);
    check("flush_ready", 32'(in_ready_o), 32'd1);

    // regWrite gating once the payload is consumed
    out_ready_i = 1'b0;
    drive(1'b1, 2'b11, 16'h00C1, 3'd6, 16'h1234);
    step();
    check("gate_wb_valid", 32'(WB_o), 32'h3);
    check("gate_mem", 32'(memReadData_o), 32'h1234);
    drive(1'b0, 2'b00, 16'h0000, 3'd0, 16'h0000);
    out_ready_i = 1'b1;
    step();
    check("gate_valid_low", 32'(out_valid_o), 32'd0);
    check("gate_wb_invalid", 32'(WB_o), 32'h2);
    check("gate_fu_hold", 32'(FUresult_o), 32'h00C1);

    // Asynchronous reset mid-cycle while full
    out_ready_i = 1'b0;
    drive(1'b1, 2'b01, 16'h00D1, 3'd7, 16'h5555);
    step();
    drive(1'b1, 2'b01, 16'h00D2, 3'd2, 16'h6666);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid_o), 32'd0);
    check("async_rst_ready", 32'(in_ready_o), 32'd1);
    check("async_rst_fu", 32'(FUresult_o), 32'd0);
    check("async_rst_rd", 32'(RDaddr_o), 32'd0);
    check("async_rst_mem", 32'(memReadData_o), 32'd0);
    check("async_rst_wb", 32'(WB_o), 32'd0);
    @(negedge clk_i);
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b1, 2'b01, 16'h00E1, 3'd1, 16'h0000);
    step();
    check("post_rst_accept_valid", 32'(out_valid_o), 32'd1);
    check("post_rst_accept_fu", 32'(FUresult_o), 32'h00E1);
    drive(1'b0, 2'b00, 16'h0000, 3'd0, 16'h0000);
    step();
    check("post_rst_no_skid", 32'(out_valid_o), 32'd0);

`ifdef PIPE_MEMWB_FWD_EN
    // Forwarding hit on a load result and the x0 exclusion
    out_ready_i = 1'b0;
    drive(1'b1, 2'b11, 16'h1234, 3'd3, 16'hBEEF);
    step();
    fwdQueryAddr_i = 3'd3;
    #1;
    check("fwd_hit", 32'(fwdHit_o), 32'd1);
    check("fwd_data_mem", 32'(fwdData_o), 32'hBEEF);
    fwdQueryAddr_i = 3'd2;
    #1;
    check("fwd_miss_addr", 32'(fwdHit_o), 32'd0);
    out_ready_i = 1'b1;
    drive(1'b1, 2'b01, 16'h4321, 3'd0, 16'hAAAA);
    step();
    drive(1'b0, 2'b00, 16'h0000, 3'd0, 16'h0000);
    out_ready_i    = 1'b0;
    fwdQueryAddr_i = 3'd0;
    #1;
    check("fwd_x0_no_hit", 32'(fwdHit_o), 32'd0);
    check("fwd_data_fu", 32'(fwdData_o), 32'h4321);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
